mandelbrot_coord_gen: RTL and testbench

MANDELBROT_COORD_GEN -- requirements
Module: mandelbrot_coord_gen

---
 rtl/mandelbrot_coord_gen.sv | 118 +++++++++++
 tb/tb_mandelbrot_coord_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_coord_gen.sv
// Coordinate generator for a Mandelbrot renderer: walks a HRES x VRES pixel grid in raster
// order and presents each pixel's fixed-point (x, y) coordinate and address over a valid/ready link.
module mandelbrot_coord_gen #(
  parameter int FPW  = 27,
  parameter int AW   = 11,
  parameter int HRES = 64,
  parameter int VRES = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_en,
  input  logic           start,
  input  logic           stop,
  input  logic [FPW-1:0] x_start,
  input  logic [FPW-1:0] y_start,
  input  logic [FPW-1:0] x_step,
  input  logic [FPW-1:0] y_step,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic [FPW-1:0] x_man,
  output logic [FPW-1:0] y_man,
  output logic [AW-1:0]  adr_o,
  output logic           busy,
  output logic           done,
  output logic           state_dbg
);

  localparam int CW = (HRES > 1) ? $clog2(HRES) : 1;
  localparam int RW = (VRES > 1) ? $clog2(VRES) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(HRES - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(VRES - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t         state, next_state;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [FPW-1:0] x_start_q, x_step_q, y_step_q;
  logic           xfer, last, load;

  // Handshake: a pixel transfers on an enabled edge where out_vld and out_rdy are both high;
  // while out_vld is high without a transfer, x_man/y_man/adr_o stay stable.
  assign out_vld   = (state == RUN);
  assign busy      = (state == RUN);
  assign state_dbg = state;
  assign last      = (col == COL_LAST) && (row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (rst)         state <= IDLE;
    else if (clk_en) state <= next_state;
  end

  // stop outranks a same-cycle transfer, so an aborted frame never raises done
  always_comb begin
    next_state = state;
    xfer       = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          next_state = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          next_state = IDLE;
        end else if (out_rdy) begin
          xfer = 1'b1;
          if (last) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_man     <= '0;
      y_man     <= '0;
      adr_o     <= '0;
      col       <= '0;
      row       <= '0;
      x_start_q <= '0;
      x_step_q  <= '0;
      y_step_q  <= '0;
      done      <= 1'b0;
    end else if (clk_en) begin
      done <= 1'b0;
      if (load) begin
        x_start_q <= x_start;
        x_step_q  <= x_step;
        y_step_q  <= y_step;
        x_man     <= x_start;
        y_man     <= y_start;
        adr_o     <= '0;
        col       <= '0;
        row       <= '0;
      end else if (xfer) begin
        if (last) begin
          // address stays on the final pixel rather than wrapping into a new frame
          done <= 1'b1;
        end else if (col != COL_LAST) begin
          col   <= col + CW'(1);
          x_man <= x_man + x_step_q;
          adr_o <= adr_o + AW'(1);
        end else begin
          col   <= '0;
          row   <= row + RW'(1);
          x_man <= x_start_q;
          y_man <= y_man + y_step_q;
          adr_o <= adr_o + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mandelbrot_coord_gen.sv
// Bench for mandelbrot_coord_gen: directed scenarios plus random frames, checked by a
// negedge monitor against a raster-order reference model held in an expected queue.
module tb_mandelbrot_coord_gen;

  localparam int FPW  = 27;
  localparam int AW   = 3;
  localparam int HRES = 4;
  localparam int VRES = 2;
  localparam int W    = AW + 2 * FPW;

  logic           clk = 1'b0;
  logic           rst, clk_en, start, stop, out_rdy;
  logic [FPW-1:0] x_start, y_start, x_step, y_step;
  logic           out_vld, busy, done, state_dbg;
  logic [FPW-1:0] x_man, y_man;
  logic [AW-1:0]  adr_o;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  mandelbrot_coord_gen #(.FPW(FPW), .AW(AW), .HRES(HRES), .VRES(VRES)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .stop(stop),
    .x_start(x_start), .y_start(y_start), .x_step(x_step), .y_step(y_step),
    .out_vld(out_vld), .out_rdy(out_rdy), .x_man(x_man), .y_man(y_man),
    .adr_o(adr_o), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_frame(input logic [FPW-1:0] xs, input logic [FPW-1:0] xst,
                            input logic [FPW-1:0] ys, input logic [FPW-1:0] yst);
    logic [FPW-1:0] xv, yv;
    logic [AW-1:0]  av;
    for (int r = 0; r < VRES; r++) begin
      for (int c = 0; c < HRES; c++) begin
        xv = xs + FPW'(c * xst);
        yv = ys + FPW'(r * yst);
        av = AW'(r * HRES + c);
        exp_q.push_back({av, xv, yv});
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic           m_busy = 1'b0, m_done = 1'b0;
  logic           p_vld = 1'b0, p_rst = 1'b0, p_en = 1'b0, p_rdy = 1'b0, p_stop = 1'b0;
  logic [FPW-1:0] p_x, p_y;
  logic [AW-1:0]  p_adr;

  always @(negedge clk) begin
    logic [W-1:0] e;
    chk("out_vld", 64'(out_vld), 64'(m_busy));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    if (p_rst)
      chk("reset_outputs", 64'({adr_o, x_man, y_man}), 64'd0);
    if (p_vld && !p_rst && (!p_en || (!p_rdy && !p_stop)))
      chk("hold", 64'({out_vld, adr_o, x_man, y_man}), 64'({1'b1, p_adr, p_x, p_y}));

    p_vld = out_vld; p_rst = rst; p_en = clk_en; p_rdy = out_rdy; p_stop = stop;
    p_x = x_man; p_y = y_man; p_adr = adr_o;

    if (rst) begin
      exp_q.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (clk_en) begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start && !stop) begin
          push_frame(x_start, x_step, y_start, y_step);
          m_busy = 1'b1;
        end
      end else if (stop) begin
        exp_q.delete();
        m_busy = 1'b0;
      end else if (out_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", 64'(adr_o), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("pixel", 64'({adr_o, x_man, y_man}), 64'(e));
          if (exp_q.size() == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ref_params();
    x_start = 27'h7800000;
    x_step  = 27'h0200000;
    y_start = 27'h0400000;
    y_step  = 27'h7E00000;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    if (!done) begin
      failures++;
      $display("FAIL %s: done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_adr(input logic [AW-1:0] v, input int budget);
    int n = 0;
    while (!(out_vld && adr_o == v) && n < budget) begin
      tick();
      n++;
    end
    if (!(out_vld && adr_o == v)) begin
      failures++;
      $display("FAIL wait_adr: adr %0d not reached, at %0d", v, adr_o);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; clk_en = 1'b1; start = 1'b0; stop = 1'b0; out_rdy = 1'b1;
    set_ref_params();
    tick(); tick();
    rst = 1'b0;
    tick();

    // reference frame, consumer always ready
    start_frame();
    wait_done("basic", 40);
    tick();

    // consumer alternating ready/not-ready
    out_rdy = 1'b0;
    start_frame();
    for (int i = 0; i < 40 && !done; i++) begin
      out_rdy = ~out_rdy;
      tick();
    end
    chk("toggle_done", 64'(done), 64'd1);
    out_rdy = 1'b1;
    tick();

    // clock enable held low mid-frame
    start_frame();
    tick(); tick();
    clk_en = 1'b0;
    repeat (5) tick();
    clk_en = 1'b1;
    wait_done("clk_en_gap", 40);
    tick();

    // start ignored mid-frame, then stop together with a transfer
    start_frame();
    wait_adr(3'd3, 20);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_adr(3'd5, 20);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_vld", 64'(out_vld), 64'd0);
    chk("stop_busy", 64'(busy), 64'd0);
    tick(); tick();

    // reset mid-frame, then restart
    start_frame();
    wait_adr(3'd2, 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_outputs", 64'({out_vld, busy, done, adr_o, x_man, y_man}), 64'd0);
    start_frame();
    chk("restart", 64'({out_vld, adr_o, x_man}), 64'({1'b1, 3'd0, 27'h7800000}));
    wait_done("after_reset", 40);
    tick();

    // start in the done cycle: back-to-back frames
    start_frame();
    wait_done("b2b_first", 40);
    start_frame();
    chk("b2b_start", 64'({out_vld, adr_o}), 64'({1'b1, 3'd0}));
    wait_done("b2b_second", 40);
    tick();

    // random frames with random ready and clock enable
    for (int f = 0; f < 8; f++) begin
      x_start = FPW'($urandom); x_step = FPW'($urandom);
      y_start = FPW'($urandom); y_step = FPW'($urandom);
      start_frame();
      for (int i = 0; i < 2000 && !done; i++) begin
        out_rdy = 1'($urandom_range(0, 1));
        clk_en  = ($urandom_range(0, 4) != 0);
        start   = 1'($urandom_range(0, 1));
        tick();
      end
      start = 1'b0; clk_en = 1'b1; out_rdy = 1'b1;
      chk("random_done", 64'(done), 64'd1);
      tick(); tick();
    end

    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
